// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped peripherals on the CPU
// data bus (LED, switches, UART transmitter).
//   - bus address map constants
//   - UART transmitter state encoding
//   - bit positions inside the UART status byte
package mmio_pkg;

    localparam logic [15:0] LED_ADDR  = 16'd999;
    localparam logic [15:0] SW_ADDR   = 16'd998;
    localparam logic [15:0] DATA_ADDR = 16'd997;
    localparam logic [15:0] STAT_ADDR = 16'd996;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and a combinational
// head output (rdata shows the oldest entry whenever empty=0).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push, wdata     write request and data; accepted when not full, or when
//                   a pop happens on the same edge
//   pop             remove the head entry (ignored when empty)
//   rdata           current head entry
//   full, empty     occupancy flags
//   count           number of stored entries, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (8N1, LSB first).
// The CPU stores bytes to DATA_ADDR; they are queued in a sync_fifo and
// shifted out on tx. STAT_ADDR reads back a status byte with RAM-like
// one-cycle latency and accepts an overflow-clear write (din[3]=1).
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   addr, we   CPU bus address (valid every cycle) and write strobe
//   din        CPU write data
//   rd_data    registered status byte (0 when the previous addr was not STAT_ADDR)
//   rd_hit     registered: previous cycle's addr was STAT_ADDR
//   tx         serial line, idles high, driven from a register
// Status byte: bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky),
//   bit4 parity advertised, bits7:5 zero.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit (frame becomes 11 bit times).
module mmio_uart_tx #(
    parameter int          CLK_HZ    = 50000000,
    parameter int          BAUD      = 115200,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DATA_ADDR = 16'd997,
    parameter logic [15:0] STAT_ADDR = 16'd996
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  din,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic        tx
);

    import mmio_pkg::*;

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW   = $clog2(DIV);
    localparam int CNTW = $clog2(DEPTH) + 1;

    uart_tx_state_t  state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
`ifdef UART_TX_PARITY_EN
    logic            par_bit;
`endif
    logic            ovf;
    logic [7:0]      status;

    logic            push_req;
    logic            clr_req;
    logic            pop;
    logic            ovf_set;
    logic            bit_done;

    logic [7:0]      fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CNTW-1:0] fifo_count;

    assign push_req = we && (addr == DATA_ADDR);
    assign clr_req  = we && (addr == STAT_ADDR) && din[3];
    assign pop      = (state == IDLE) && !fifo_empty;
    // The FIFO accepts a push into a full queue only when the transmitter
    // drains an entry on the same edge; otherwise the byte is lost.
    assign ovf_set  = push_req && (fifo_count == CNTW'(DEPTH)) && !pop;
    assign bit_done = (baud_cnt == CW'(DIV - 1));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata (din),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = (state != IDLE);
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf;
`ifdef UART_TX_PARITY_EN
        status[ST_PAR]   = 1'b1;
`endif
    end

    // tx is registered from the state held before each edge, so the line
    // lags the state by one clock: a pop at edge N+1 drives the start bit
    // from edge N+2, and every bit still lasts exactly DIV clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_head;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^fifo_head;
`endif
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (bit_done) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx <= par_bit;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_done) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf     <= 1'b0;
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else begin
            // A drop on the same edge as a clear leaves the flag set.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_req) begin
                ovf <= 1'b0;
            end
            rd_hit  <= (addr == STAT_ADDR);
            rd_data <= (addr == STAT_ADDR) ? status : '0;
        end
    end

endmodule
